// File: rtl/uart_tx_arbiter_if.sv
// Request/UART bundle shared by the byte-stream arbiter and its environment.
// master: requesters plus UART busy source; slave: the arbiter itself.
interface uart_tx_arbiter_if #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 8
);
    logic [N-1:0]   i_req_valid;
    logic [N*W-1:0] i_req_data;
    logic [N-1:0]   i_req_last;
    logic [N-1:0]   o_req_ready;
    logic [W-1:0]   o_uart_data;
    logic           o_uart_we;
    logic           i_uart_busy;
    logic [N-1:0]   o_grant;
    logic           o_locked;

    modport master (
        output i_req_valid, i_req_data, i_req_last, i_uart_busy,
        input  o_req_ready, o_uart_data, o_uart_we, o_grant, o_locked
    );

    modport slave (
        input  i_req_valid, i_req_data, i_req_last, i_uart_busy,
        output o_req_ready, o_uart_data, o_uart_we, o_grant, o_locked
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one UART transmitter core
// between N byte-stream requesters; one byte per UART frame.
module uart_tx_arbiter #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 8
) (
    input  logic            i_clk,
    input  logic            i_rst,
    uart_tx_arbiter_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(N);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT_HI, WAIT_LO} state_t;

    state_t           r_state, w_state_nxt;
    logic [W-1:0]     r_data, w_data_nxt;
    logic [N-1:0]     r_grant, w_grant_nxt;
    logic             r_locked, w_locked_nxt;
    logic             r_pend_last, w_pend_last_nxt;
    logic [IDX_W-1:0] r_owner, w_owner_nxt;
    logic [IDX_W-1:0] r_ptr, w_ptr_nxt;

    logic             w_sel_found;
    logic [IDX_W-1:0] w_sel_idx;
    logic [IDX_W-1:0] w_cand;
    logic             w_xfer;

    // A held lock restricts eligibility to the owner; otherwise scan from ptr+1.
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_idx   = '0;
        w_cand      = '0;
        if (r_locked) begin
            w_sel_found = bus.i_req_valid[r_owner];
            w_sel_idx   = r_owner;
        end else begin
            for (int unsigned i = 1; i <= N; i++) begin
                w_cand = IDX_W'((32'(r_ptr) + i) % N);
                if (!w_sel_found && bus.i_req_valid[w_cand]) begin
                    w_sel_found = 1'b1;
                    w_sel_idx   = w_cand;
                end
            end
        end
    end

    assign w_xfer = (r_state == IDLE) && !bus.i_uart_busy && w_sel_found;

    always_comb begin
        w_state_nxt     = r_state;
        w_data_nxt      = r_data;
        w_grant_nxt     = r_grant;
        w_locked_nxt    = r_locked;
        w_pend_last_nxt = r_pend_last;
        w_owner_nxt     = r_owner;
        w_ptr_nxt       = r_ptr;
        unique case (r_state)
            IDLE: begin
                if (w_xfer) begin
                    w_data_nxt      = bus.i_req_data[32'(w_sel_idx) * W +: W];
                    w_grant_nxt     = N'(1) << w_sel_idx;
                    w_owner_nxt     = w_sel_idx;
                    w_locked_nxt    = !bus.i_req_last[w_sel_idx];
                    w_pend_last_nxt = bus.i_req_last[w_sel_idx];
                    w_state_nxt     = LOAD;
                end
            end
            LOAD: begin
                w_state_nxt = WAIT_HI;
            end
            WAIT_HI: begin
                if (bus.i_uart_busy) begin
                    w_state_nxt = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (!bus.i_uart_busy) begin
                    w_state_nxt = IDLE;
                    // End of packet: release lock and rotate priority past the owner.
                    if (r_pend_last) begin
                        w_locked_nxt = 1'b0;
                        w_ptr_nxt    = r_owner;
                        w_grant_nxt  = '0;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_data      <= '0;
            r_grant     <= '0;
            r_locked    <= 1'b0;
            r_pend_last <= 1'b0;
            r_owner     <= '0;
            r_ptr       <= IDX_W'(N - 1);
        end else begin
            r_state     <= w_state_nxt;
            r_data      <= w_data_nxt;
            r_grant     <= w_grant_nxt;
            r_locked    <= w_locked_nxt;
            r_pend_last <= w_pend_last_nxt;
            r_owner     <= w_owner_nxt;
            r_ptr       <= w_ptr_nxt;
        end
    end

    assign bus.o_req_ready = w_xfer ? (N'(1) << w_sel_idx) : '0;
    assign bus.o_uart_we   = (r_state == LOAD);
    assign bus.o_uart_data = r_data;
    assign bus.o_grant     = r_grant;
    assign bus.o_locked    = r_locked;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter: packet sources, a UART busy model and
// a transaction-level arbitration reference model.
module tb_uart_tx_arbiter;
    localparam int unsigned N       = 4;
    localparam int unsigned W       = 8;
    localparam int          PH0_CYC = 300;
    localparam int          GEN_CYC = 4000;
    localparam int          MAX_CYC = 8000;

    logic i_clk = 1'b0;
    logic i_rst;

    uart_tx_arbiter_if #(.N(N), .W(W)) bus ();

    uart_tx_arbiter #(.N(N), .W(W)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    always #5 i_clk = ~i_clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Source state
    logic [W-1:0] cur_data [N];
    logic         cur_last [N];
    bit           src_vld  [N];
    bit           has_byte [N];
    int           pkt_left [N];
    int           stall    [N];

    // Reference model of the arbitration rules
    bit           m_locked;
    int           m_owner;
    int           m_ptr;
    logic [N-1:0] m_grant;
    logic [W-1:0] m_data;
    bit           m_pend_last;
    bit           m_inflight;
    bit           m_saw_busy;
    bit           m_we_now;

    // UART busy model
    bit busy_sched;
    int busy_delay;
    int busy_len;

    bit rst_req, in_rst;
    int n_resets, last_rst_cyc;
    int unsigned n_we, n_xfer;

    function automatic int pick(input logic [N-1:0] v);
        if (m_locked) return v[m_owner] ? m_owner : -1;
        for (int d = 1; d <= int'(N); d++) begin
            if (v[(m_ptr + d) % int'(N)]) return (m_ptr + d) % int'(N);
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_locked    = 1'b0;
        m_owner     = 0;
        m_ptr       = int'(N) - 1;
        m_grant     = '0;
        m_data      = '0;
        m_pend_last = 1'b0;
        m_inflight  = 1'b0;
        m_saw_busy  = 1'b0;
        m_we_now    = 1'b0;
    endtask

    function automatic bit drained();
        for (int k = 0; k < int'(N); k++) begin
            if (has_byte[k] || src_vld[k] || pkt_left[k] != 0) return 1'b0;
        end
        return !m_inflight;
    endfunction

    task automatic drive_inputs(input int cyc);
        if (rst_req) begin
            i_rst   = 1'b1;
            in_rst  = 1'b1;
            rst_req = 1'b0;
        end else begin
            i_rst  = 1'b0;
            in_rst = 1'b0;
        end

        if (in_rst) begin
            busy_sched      = 1'b0;
            bus.i_uart_busy = 1'b0;
        end else if (busy_sched && busy_delay > 0) begin
            busy_delay--;
            bus.i_uart_busy = 1'b0;
        end else if (busy_sched) begin
            bus.i_uart_busy = 1'b1;
            busy_len--;
            if (busy_len == 0) busy_sched = 1'b0;
        end else begin
            // Occasional spurious busy while idle must block selection.
            bus.i_uart_busy = (!m_inflight && cyc >= PH0_CYC && $urandom_range(0, 9) == 0);
        end

        for (int k = 0; k < int'(N); k++) begin
            if (!src_vld[k]) begin
                if (stall[k] > 0) begin
                    stall[k]--;
                end else begin
                    if (!has_byte[k]) begin
                        if (pkt_left[k] == 0 && cyc < GEN_CYC)
                            pkt_left[k] = (cyc < PH0_CYC) ? 1 : int'($urandom_range(1, 4));
                        if (pkt_left[k] > 0) begin
                            has_byte[k] = 1'b1;
                            cur_data[k] = (cyc < PH0_CYC) ? W'(8'hA0 + k) : W'($urandom);
                            cur_last[k] = (pkt_left[k] == 1);
                        end
                    end
                    if (has_byte[k] && (cyc < PH0_CYC || $urandom_range(0, 9) < 6))
                        src_vld[k] = 1'b1;
                end
            end
            bus.i_req_valid[k]        = src_vld[k];
            bus.i_req_data[k*W +: W]  = src_vld[k] ? cur_data[k] : W'($urandom);
            bus.i_req_last[k]         = src_vld[k] ? cur_last[k] : 1'($urandom);
        end
    endtask

    task automatic check_and_update(input int cyc);
        logic [N-1:0] exp_ready;
        int           sel;
        bit           busy_now;
        bit           next_we;

        busy_now = bus.i_uart_busy;
        if (in_rst) begin
            model_reset();
            check("rst_grant", bus.o_grant, '0);
            check("rst_locked", bus.o_locked, 0);
            check("rst_we", bus.o_uart_we, 0);
            check("rst_data", bus.o_uart_data, '0);
            return;
        end

        sel       = (!m_inflight && !busy_now) ? pick(bus.i_req_valid) : -1;
        exp_ready = (sel >= 0) ? (N'(1) << sel) : '0;

        check("ready", bus.o_req_ready, exp_ready);
        check("we", bus.o_uart_we, m_we_now);
        check("data", bus.o_uart_data, m_data);
        check("grant", bus.o_grant, m_grant);
        check("locked", bus.o_locked, m_locked);

        if (bus.o_uart_we === 1'b1) begin
            n_we++;
            busy_sched = 1'b1;
            busy_delay = $urandom_range(0, 2);
            busy_len   = $urandom_range(1, 6);
        end

        next_we = 1'b0;
        if (sel >= 0) begin
            n_xfer++;
            m_data      = cur_data[sel];
            m_grant     = N'(1) << sel;
            m_owner     = sel;
            m_pend_last = cur_last[sel];
            m_locked    = !cur_last[sel];
            m_inflight  = 1'b1;
            m_saw_busy  = 1'b0;
            next_we     = 1'b1;
            src_vld[sel]  = 1'b0;
            has_byte[sel] = 1'b0;
            pkt_left[sel]--;
            if (!cur_last[sel] && $urandom_range(0, 7) == 0) stall[sel] = 50;
        end else if (m_inflight && !m_we_now) begin
            if (m_saw_busy && !busy_now) begin
                m_inflight = 1'b0;
                if (m_pend_last) begin
                    m_locked = 1'b0;
                    m_ptr    = m_owner;
                    m_grant  = '0;
                end
            end else if (!m_saw_busy && busy_now) begin
                m_saw_busy = 1'b1;
            end
        end
        m_we_now = next_we;

        // Reset while a locked packet is still waiting for busy to fall.
        if (cyc >= PH0_CYC && cyc < GEN_CYC && m_inflight && m_saw_busy && busy_now &&
            busy_len > 0 && m_locked && n_resets < 3 && cyc > last_rst_cyc + 200) begin
            rst_req      = 1'b1;
            n_resets++;
            last_rst_cyc = cyc;
        end
    endtask

    initial begin
        int cyc;
        i_rst           = 1'b1;
        bus.i_req_valid = '0;
        bus.i_req_data  = '0;
        bus.i_req_last  = '0;
        bus.i_uart_busy = 1'b0;
        for (int k = 0; k < int'(N); k++) begin
            cur_data[k] = '0;
            cur_last[k] = 1'b0;
            src_vld[k]  = 1'b0;
            has_byte[k] = 1'b0;
            pkt_left[k] = 0;
            stall[k]    = 0;
        end
        model_reset();
        busy_sched   = 1'b0;
        busy_delay   = 0;
        busy_len     = 0;
        rst_req      = 1'b0;
        in_rst       = 1'b0;
        n_resets     = 0;
        last_rst_cyc = 0;
        n_we         = 0;
        n_xfer       = 0;

        @(negedge i_clk);
        check("init_grant", bus.o_grant, '0);
        check("init_locked", bus.o_locked, 0);
        check("init_we", bus.o_uart_we, 0);
        check("init_data", bus.o_uart_data, '0);
        check("init_ready", bus.o_req_ready, '0);

        cyc = 0;
        while (cyc < MAX_CYC && !(cyc >= GEN_CYC && drained())) begin
            @(posedge i_clk);
            #1;
            drive_inputs(cyc);
            @(negedge i_clk);
            check_and_update(cyc);
            cyc++;
        end

        check("drained", 32'(drained()), 1);
        check("we_count", n_we, n_xfer);
        check("resets_done", 32'(n_resets > 0), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
